// File: rtl/vec_addsub_seq.sv
// Sequential vector add/subtract: walks an LMUL register group one register at a
// time (read -> operand capture -> write-back) through an external adder array.

module vec_addsub_be_lane #(
  parameter int IDX = 0
) (
  input  logic [31:0] base,
  input  logic [31:0] lim,
  output logic        en
);
  assign en = (base + 32'(IDX)) < lim;
endmodule

module vec_addsub_seq #(
  parameter int VLEN   = 512,
  parameter int REG_AW = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   ready,
  input  logic                   sub,
  input  logic [1:0]             sew,
  input  logic [1:0]             lmul,
  input  logic [$clog2(VLEN):0]  vl,
  input  logic [REG_AW-1:0]      vs1,
  input  logic [REG_AW-1:0]      vs2,
  input  logic [REG_AW-1:0]      vd,
  output logic                   rd_en,
  output logic [REG_AW-1:0]      rd_addr1,
  output logic [REG_AW-1:0]      rd_addr2,
  input  logic [VLEN-1:0]        rd_data1,
  input  logic [VLEN-1:0]        rd_data2,
  output logic                   as_ctrl,
  output logic                   as_sew_16_32,
  output logic                   as_sew_32,
  output logic [VLEN-1:0]        as_a,
  output logic [VLEN-1:0]        as_b,
  input  logic [VLEN-1:0]        as_sum,
  output logic                   wr_en,
  output logic [REG_AW-1:0]      wr_addr,
  output logic [VLEN-1:0]        wr_data,
  output logic [VLEN/8-1:0]      wr_be,
  output logic                   done,
  output logic                   error
);
  localparam int NB = VLEN / 8;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic                  sub_q;
  logic [1:0]            sew_q, lmul_q;
  logic [$clog2(VLEN):0] vl_q;
  logic [REG_AW-1:0]     vs1_q, vs2_q, vd_q;

  // Group overflow: any base + N-1 that carries past the register-file top.
  logic [REG_AW+3:0] grp_m1, top1, top2, topd;
  logic              illegal;
  assign grp_m1  = (REG_AW+4)'((32'd1 << lmul) - 32'd1);
  assign top1    = {4'b0, vs1} + grp_m1;
  assign top2    = {4'b0, vs2} + grp_m1;
  assign topd    = {4'b0, vd}  + grp_m1;
  assign illegal = (sew == 2'b11) || (|top1[REG_AW+3:REG_AW]) ||
                   (|top2[REG_AW+3:REG_AW]) || (|topd[REG_AW+3:REG_AW]);

  logic [3:0] grp_n;
  logic       last;
  assign grp_n = 4'd1 << lmul_q;
  assign last  = ({1'b0, cnt} == grp_n - 4'd1);

  // Byte b of the current register is live when its absolute byte index is below vl*esize.
  logic [31:0]   be_base, be_lim;
  logic [NB-1:0] be_nxt;
  assign be_base = 32'(cnt) * 32'(NB);
  assign be_lim  = 32'(vl_q) << sew_q;

  for (genvar b = 0; b < NB; b++) begin : g_be
    vec_addsub_be_lane #(.IDX(b)) u_lane (.base(be_base), .lim(be_lim), .en(be_nxt[b]));
  end

  assign wr_data = wr_en ? as_sum : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      sub_q        <= 1'b0;
      sew_q        <= '0;
      lmul_q       <= '0;
      vl_q         <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      ready        <= 1'b1;
      rd_en        <= 1'b0;
      rd_addr1     <= '0;
      rd_addr2     <= '0;
      as_ctrl      <= 1'b0;
      as_sew_16_32 <= 1'b0;
      as_sew_32    <= 1'b0;
      as_a         <= '0;
      as_b         <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_be        <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sub_q  <= sub;
          sew_q  <= sew;
          lmul_q <= lmul;
          vl_q   <= vl;
          vs1_q  <= vs1;
          vs2_q  <= vs2;
          vd_q   <= vd;
          cnt    <= '0;
          if (illegal) begin
            error <= 1'b1;
          end else if (vl == '0) begin
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state    <= READ;
            rd_en    <= 1'b1;
            rd_addr1 <= vs1;
            rd_addr2 <= vs2;
            ready    <= 1'b0;
          end
        end
        READ: begin
          state        <= EXEC;
          as_ctrl      <= sub_q;
          as_sew_16_32 <= (sew_q == 2'b01) || (sew_q == 2'b10);
          as_sew_32    <= (sew_q == 2'b10);
        end
        EXEC: begin
          state   <= WRITE;
          as_a    <= rd_data1;
          as_b    <= rd_data2;
          wr_en   <= 1'b1;
          wr_addr <= vd_q + REG_AW'(cnt);
          wr_be   <= be_nxt;
        end
        WRITE: begin
          if (!last) begin
            state    <= READ;
            cnt      <= cnt + 3'd1;
            rd_en    <= 1'b1;
            rd_addr1 <= vs1_q + REG_AW'(cnt + 3'd1);
            rd_addr2 <= vs2_q + REG_AW'(cnt + 3'd1);
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_addsub_seq.sv
// Bench for vec_addsub_seq: register-file and adder models around the DUT, a
// table of operations checked through a write scoreboard, plus reset/start corner cases.

module tb_vec_addsub_seq;
  localparam int VLEN = 512, REG_AW = 5, NB = VLEN / 8, NREG = 32;
  localparam int VW = $clog2(VLEN) + 1;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [1:0] sew = '0, lmul = '0;
  logic [VW-1:0] vl = '0;
  logic [REG_AW-1:0] vs1 = '0, vs2 = '0, vd = '0;
  logic ready, rd_en, as_ctrl, as_sew_16_32, as_sew_32, wr_en, done, error;
  logic [REG_AW-1:0] rd_addr1, rd_addr2, wr_addr;
  logic [VLEN-1:0] rd_data1 = '0, rd_data2 = '0, as_a, as_b, as_sum, wr_data;
  logic [NB-1:0] wr_be;

  always #5 clk = ~clk;

  vec_addsub_seq #(.VLEN(VLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .sub(sub), .sew(sew),
    .lmul(lmul), .vl(vl), .vs1(vs1), .vs2(vs2), .vd(vd), .rd_en(rd_en),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .as_ctrl(as_ctrl), .as_sew_16_32(as_sew_16_32), .as_sew_32(as_sew_32),
    .as_a(as_a), .as_b(as_b), .as_sum(as_sum), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .done(done), .error(error));

  function automatic logic [VLEN-1:0] addsub(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                             input logic [1:0] s, input logic sb);
    logic [VLEN-1:0] r;
    r = '0;
    case (s)
      2'd0: for (int i = 0; i < VLEN/8; i++)
              r[i*8 +: 8] = sb ? a[i*8 +: 8] - b[i*8 +: 8] : a[i*8 +: 8] + b[i*8 +: 8];
      2'd1: for (int i = 0; i < VLEN/16; i++)
              r[i*16 +: 16] = sb ? a[i*16 +: 16] - b[i*16 +: 16] : a[i*16 +: 16] + b[i*16 +: 16];
      default: for (int i = 0; i < VLEN/32; i++)
              r[i*32 +: 32] = sb ? a[i*32 +: 32] - b[i*32 +: 32] : a[i*32 +: 32] + b[i*32 +: 32];
    endcase
    return r;
  endfunction

  // External adder array, steered only by the DUT's control outputs.
  logic [1:0] as_sew_dec;
  always_comb begin
    as_sew_dec = 2'd0;
    if (as_sew_32) as_sew_dec = 2'd2;
    else if (as_sew_16_32) as_sew_dec = 2'd1;
    as_sum = addsub(as_a, as_b, as_sew_dec, as_ctrl);
  end

  // Register file: written only by the main process, read with one-cycle latency.
  logic [VLEN-1:0] rf [NREG];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data1 <= rf[rd_addr1];
      rd_data2 <= rf[rd_addr2];
    end
  end

  typedef struct {
    logic [REG_AW-1:0] addr;
    logic [VLEN-1:0]   data;
    logic [NB-1:0]     be;
  } wexp_t;
  wexp_t sbq[$];

  typedef struct {
    logic sub; logic [1:0] sew; logic [1:0] lmul;
    int vl; int vs1; int vs2; int vd;
    logic err; int done_cyc; logic pat; logic [31:0] w1; logic [31:0] w2;
  } op_t;

  function automatic op_t mk(input int sb, input int sw, input int lm, input int v,
                             input int a, input int b, input int d, input int e,
                             input int dc, input int p, input logic [31:0] x, input logic [31:0] y);
    op_t o;
    o.sub = sb[0]; o.sew = sw[1:0]; o.lmul = lm[1:0]; o.vl = v;
    o.vs1 = a; o.vs2 = b; o.vd = d; o.err = e[0]; o.done_cyc = dc;
    o.pat = p[0]; o.w1 = x; o.w2 = y;
    return o;
  endfunction

  int n_cmp = 0, n_bad = 0;
  int n_rd, n_wr, n_err, done_cyc, viol;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_rd = 0; n_wr = 0; n_err = 0; done_cyc = -1; viol = 0;
  endtask

  function automatic bit outs_idle_zero();
    return ready === 1'b1 && rd_en === 1'b0 && wr_en === 1'b0 && done === 1'b0 &&
           error === 1'b0 && rd_addr1 === '0 && rd_addr2 === '0 && wr_addr === '0 &&
           as_ctrl === 1'b0 && as_sew_16_32 === 1'b0 && as_sew_32 === 1'b0 &&
           as_a === '0 && as_b === '0 && wr_data === '0 && wr_be === '0;
  endfunction

  // One cycle: sample on the falling edge, check writes against the scoreboard, commit them.
  task automatic tick(input int c);
    wexp_t e;
    @(negedge clk);
    if (int'(rd_en) + int'(wr_en) + int'(done) + int'(error) > 1) viol++;
    if (rd_en) n_rd++;
    if (error) n_err++;
    if (done && done_cyc < 0) done_cyc = c;
    if (wr_en) begin
      n_wr++;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got write to addr %0d, expected no write", wr_addr);
      end else begin
        e = sbq.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || wr_be !== e.be) begin
          n_bad++;
          $display("FAIL wr_check: got addr %0d be %h data %h expected addr %0d be %h data %h",
                   wr_addr, wr_be, wr_data, e.addr, e.be, e.data);
        end
      end
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) rf[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
    end
  endtask

  // Push the expected write sequence computed from a snapshot of the register file.
  task automatic push_exp(input op_t o, input int nregs);
    logic [VLEN-1:0] m [NREG];
    wexp_t e;
    m = rf;
    for (int i = 0; i < nregs; i++) begin
      e.addr = REG_AW'(o.vd + i);
      e.data = addsub(m[o.vs1 + i], m[o.vs2 + i], o.sew, o.sub);
      for (int b = 0; b < NB; b++) e.be[b] = (i * NB + b) < o.vl * (1 << o.sew);
      for (int b = 0; b < NB; b++) if (e.be[b]) m[o.vd + i][b*8 +: 8] = e.data[b*8 +: 8];
      sbq.push_back(e);
    end
  endtask

  task automatic drive_start(input op_t o);
    sub = o.sub; sew = o.sew; lmul = o.lmul; vl = VW'(o.vl);
    vs1 = REG_AW'(o.vs1); vs2 = REG_AW'(o.vs2); vd = REG_AW'(o.vd);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input string nm, input op_t o, input int inj_cyc);
    int n, exp_xfer, c;
    n = 1 << o.lmul;
    exp_xfer = (o.err || o.vl == 0) ? 0 : n;
    if (o.pat)
      for (int i = 0; i < n; i++) begin
        rf[o.vs1 + i] = {VLEN/32{o.w1}};
        rf[o.vs2 + i] = {VLEN/32{o.w2}};
      end
    if (exp_xfer > 0) push_exp(o, n);
    clr_counts();
    drive_start(o);
    for (c = 1; c <= 60; c++) begin
      tick(c);
      if (c == inj_cyc) begin
        start = 1'b1; sew = 2'b11; lmul = 2'd3; vd = REG_AW'(28); vl = '0;
      end else if (c == inj_cyc + 1) begin
        start = 1'b0;
      end
      if ((o.err && c == 5) || done_cyc >= 0) break;
    end
    start = 1'b0;
    tick(99);
    chk({nm, "_done_cyc"}, done_cyc, o.err ? -1 : o.done_cyc);
    chk({nm, "_err_pulses"}, n_err, o.err ? 1 : 0);
    chk({nm, "_reads"}, n_rd, exp_xfer);
    chk({nm, "_writes"}, n_wr, exp_xfer);
    chk({nm, "_sb_left"}, sbq.size(), 0);
    chk({nm, "_exclusive"}, viol, 0);
    chk({nm, "_ready_after"}, ready, 1);
    sbq.delete();
  endtask

  op_t tbl[13];
  op_t hop;
  logic [VLEN-1:0] keep;
  logic [VLEN-1:0] exp_full;

  initial begin
    for (int i = 0; i < NREG; i++)
      for (int j = 0; j < VLEN/32; j++) rf[i][j*32 +: 32] = $urandom;

    //           sub sew lmul  vl  vs1 vs2 vd err done pat w1            w2
    tbl[0]  = mk(0, 2, 0,  16,  1,  2,  3, 0,  4, 1, 32'h00000001, 32'h7FFFFFFF);
    tbl[1]  = mk(1, 0, 1,  70,  4,  6,  8, 0,  7, 1, 32'h00000000, 32'h01010101);
    tbl[2]  = mk(0, 1, 3,   0,  0,  8, 16, 0,  1, 0, 32'h0, 32'h0);
    tbl[3]  = mk(0, 3, 0,   5,  1,  2,  3, 1,  0, 0, 32'h0, 32'h0);
    tbl[4]  = mk(0, 0, 3,  10,  0,  8, 30, 1,  0, 0, 32'h0, 32'h0);
    tbl[5]  = mk(0, 1, 2,  50, 10, 14, 20, 0, 13, 0, 32'h0, 32'h0);
    tbl[6]  = mk(1, 2, 1, 500,  0,  2,  4, 0,  7, 0, 32'h0, 32'h0);
    tbl[7]  = mk(0, 0, 2, 256, 20, 22, 20, 0, 13, 0, 32'h0, 32'h0);
    tbl[8]  = mk(1, 0, 0,  63,  1,  2,  5, 0,  4, 0, 32'h0, 32'h0);
    tbl[9]  = mk(0, 0, 0,   1,  1,  2,  5, 0,  4, 0, 32'h0, 32'h0);
    tbl[10] = mk(0, 2, 3, 100,  0,  8, 24, 0, 25, 0, 32'h0, 32'h0);
    tbl[11] = mk(0, 1, 3,   7, 25,  0,  0, 1,  0, 0, 32'h0, 32'h0);
    tbl[12] = mk(0, 0, 0, 512,  6,  7,  9, 0,  4, 0, 32'h0, 32'h0);

    clr_counts();
    tick(0);
    tick(0);
    chk("reset_outputs", outs_idle_zero(), 1);
    reset_n = 1'b1;

    exp_full = {VLEN/32{32'h80000000}};
    for (int k = 0; k < 13; k++) begin
      run_op($sformatf("vec%0d", k), tbl[k], -1);
      if (k == 0) begin
        n_cmp++;
        if (rf[3] !== exp_full) begin
          n_bad++;
          $display("FAIL vec0_result: got %h expected %h", rf[3], exp_full);
        end
      end
    end

    // start raised while the first register is in EXEC must be ignored.
    hop = mk(0, 0, 2, 256, 0, 4, 8, 0, 13, 0, 32'h0, 32'h0);
    run_op("start_in_exec", hop, 2);

    // Reset lands in the WRITE cycle of the second register of a two-register group.
    hop = mk(0, 2, 1, 32, 10, 12, 14, 0, 0, 0, 32'h0, 32'h0);
    keep = rf[15];
    push_exp(hop, 1);
    void'(sbq.pop_back());
    push_exp(hop, 1);
    clr_counts();
    drive_start(hop);
    for (int c = 1; c <= 5; c++) tick(c);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_outputs", outs_idle_zero(), 1);
    for (int c = 6; c <= 8; c++) tick(c);
    chk("rst_mid_writes", n_wr, 1);
    chk("rst_mid_sb_left", sbq.size(), 0);
    n_cmp++;
    if (rf[15] !== keep) begin
      n_bad++;
      $display("FAIL rst_mid_partial: got reg15 %h expected %h", rf[15], keep);
    end
    reset_n = 1'b1;
    #1 chk("rst_release_ready", ready, 1);

    // First edge after release must already accept a new instruction.
    hop = mk(1, 1, 0, 32, 3, 4, 5, 0, 4, 0, 32'h0, 32'h0);
    run_op("post_reset", hop, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
